bennett_square_clock: RTL and testbench

- Multi-phase square-wave Bennett clock generator for the adiabatic processor datapath (SRAM bank, decoders, pipeline latches).
- Each Bennett cycle, phases clkp[0..WIDTH-1] rise one per clock in ascending order, then fall one per clock in descending order (last raised, first released).
- Also drives Mclk (high during the falling half) and instFlag (one-clock pulse per completed cycle) for instruction sequencing.
- Consumers build inverted phases externally (clkneg = ~clkp).

---
 rtl/bennett_square_clock_pkg.sv | 20 ++
 rtl/bennett_square_clock.sv | 58 +++++
 tb/tb_bennett_square_clock.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bennett_square_clock_pkg.sv
// Shared definitions for the Bennett clock generator: default sizing and the
// per-phase decode of the step counter.
package bennett_square_clock_pkg;

    localparam int DEFAULT_WIDTH  = 10;
    localparam int DEFAULT_PERIOD = 2 * DEFAULT_WIDTH;
    localparam int DEFAULT_SW     = $clog2(DEFAULT_PERIOD);

    // Level of phase j at step s. The rising half adds phases upward and the
    // falling half releases them downward, so the last phase raised is the first released.
    function automatic logic phase_on(input int unsigned s,
                                      input int unsigned j,
                                      input int unsigned width);
        if (s < width) begin
            return (j <= s);
        end
        return (j < (2 * width - 1 - s));
    endfunction

endpackage

// File: rtl/bennett_square_clock.sv
// Multi-phase square-wave Bennett clock: phases rise in ascending order, then
// fall in descending order. Mclk marks the falling half and instFlag marks the idle slot.
module bennett_square_clock
    import bennett_square_clock_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] clkp,
    output logic             Mclk,
    output logic             instFlag
);

    localparam int PERIOD = 2 * WIDTH;
    localparam int SW     = $clog2(PERIOD);
    localparam logic [SW-1:0] S_LAST = SW'(PERIOD - 1);

    logic [SW-1:0]    s_q, s_d;
    logic [WIDTH-1:0] clkp_q, clkp_d;
    logic             mclk_q, mclk_d;
    logic             inst_q, inst_d;

    always_comb begin
        s_d = s_q + SW'(1);
        if (s_q == S_LAST) begin
            s_d = '0;
        end
    end

    // Outputs decode the next step value so that they register on the same edge as s.
    for (genvar j = 0; j < WIDTH; j++) begin : g_phase
        assign clkp_d[j] = phase_on(32'(s_d), 32'(j), 32'(WIDTH));
    end

    assign mclk_d = (s_d >= SW'(WIDTH));
    assign inst_d = (s_d == S_LAST);

    // Reset parks s on the idle slot, so the first edge after release lands on step 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q    <= S_LAST;
            clkp_q <= '0;
            mclk_q <= 1'b0;
            inst_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            clkp_q <= clkp_d;
            mclk_q <= mclk_d;
            inst_q <= inst_d;
        end
    end

    assign clkp     = clkp_q;
    assign Mclk     = mclk_q;
    assign instFlag = inst_q;

endmodule

// File: tb/tb_bennett_square_clock.sv
// Directed bench for bennett_square_clock (WIDTH = 10): per-edge vector table,
// pulse-width and period checks, asynchronous reset, and a long invariant run.
module tb_bennett_square_clock;

    localparam int W = 10;

    typedef struct {
        logic [W-1:0] clkp;
        logic         mclk;
        logic         inst;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] clkp;
    logic         Mclk;
    logic         instFlag;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl [20];

    bennett_square_clock #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .clkp     (clkp),
        .Mclk     (Mclk),
        .instFlag (instFlag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] prev;
        logic [W:0]   ext;
        longint       last_rise2;
        bit           have_rise2;
        int           c0, c9, c6m, inst_cnt;

        // Expected state after each edge of one Bennett cycle (edge 1 .. edge 20).
        tbl[0]  = '{10'h001, 1'b0, 1'b0};
        tbl[1]  = '{10'h003, 1'b0, 1'b0};
        tbl[2]  = '{10'h007, 1'b0, 1'b0};
        tbl[3]  = '{10'h00F, 1'b0, 1'b0};
        tbl[4]  = '{10'h01F, 1'b0, 1'b0};
        tbl[5]  = '{10'h03F, 1'b0, 1'b0};
        tbl[6]  = '{10'h07F, 1'b0, 1'b0};
        tbl[7]  = '{10'h0FF, 1'b0, 1'b0};
        tbl[8]  = '{10'h1FF, 1'b0, 1'b0};
        tbl[9]  = '{10'h3FF, 1'b0, 1'b0};
        tbl[10] = '{10'h1FF, 1'b1, 1'b0};
        tbl[11] = '{10'h0FF, 1'b1, 1'b0};
        tbl[12] = '{10'h07F, 1'b1, 1'b0};
        tbl[13] = '{10'h03F, 1'b1, 1'b0};
        tbl[14] = '{10'h01F, 1'b1, 1'b0};
        tbl[15] = '{10'h00F, 1'b1, 1'b0};
        tbl[16] = '{10'h007, 1'b1, 1'b0};
        tbl[17] = '{10'h003, 1'b1, 1'b0};
        tbl[18] = '{10'h001, 1'b1, 1'b0};
        tbl[19] = '{10'h000, 1'b1, 1'b1};

        // Reset held across the edge at 5 ns, sampled mid-reset.
        reset = 1'b1;
        #7;
        check("reset_clkp", 32'(clkp), 32'h0);
        check("reset_mclk", 32'(Mclk), 32'h0);
        check("reset_inst", 32'(instFlag), 32'h0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Three full cycles against the table, plus timing measurements.
        prev       = '0;
        have_rise2 = 1'b0;
        last_rise2 = 0;
        for (int c = 0; c < 3; c++) begin
            c0 = 0; c9 = 0; c6m = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                check($sformatf("clkp_c%0d_e%0d", c, i + 1), 32'(clkp), 32'(tbl[i].clkp));
                check($sformatf("mclk_c%0d_e%0d", c, i + 1), 32'(Mclk), 32'(tbl[i].mclk));
                check($sformatf("inst_c%0d_e%0d", c, i + 1), 32'(instFlag), 32'(tbl[i].inst));
                if (clkp[2] && !prev[2]) begin
                    check("rise2_edge_index", 32'(i + 1), 32'd3);
                    if (have_rise2) check("rise2_period_ns", 32'($time - last_rise2), 32'd200);
                    last_rise2 = $time;
                    have_rise2 = 1'b1;
                end
                if (clkp[9] && !prev[9]) check("rise9_edge_index", 32'(i + 1), 32'd10);
                if (!clkp[6] && prev[6]) check("fall6_falling_edge", 32'(i + 1 - 10), 32'd4);
                if (clkp[0]) c0++;
                if (clkp[9]) c9++;
                if (clkp[6] && !Mclk) c6m++;
                prev = clkp;
            end
            check($sformatf("width0_c%0d_ns", c), 32'(c0 * 10), 32'd190);
            check($sformatf("width9_c%0d_ns", c), 32'(c9 * 10), 32'd10);
            check($sformatf("width6rise_c%0d_ns", c), 32'(c6m * 10), 32'd40);
        end

        // Asynchronous reset while all phases are high.
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("pre_async_clkp", 32'(clkp), 32'h3FF);
        #2 reset = 1'b1;
        #1;
        check("async_clkp", 32'(clkp), 32'h0);
        check("async_mclk", 32'(Mclk), 32'h0);
        check("async_inst", 32'(instFlag), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_clkp", 32'(clkp), 32'h0);
            check("held_inst", 32'(instFlag), 32'h0);
        end
        #2 reset = 1'b0;

        // Long run: table match, thermometer code, single-bit change, pulse count.
        prev     = '0;
        inst_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            check("run_clkp", 32'(clkp), 32'(tbl[k % 20].clkp));
            check("run_mclk", 32'(Mclk), 32'(tbl[k % 20].mclk));
            ext = {1'b0, clkp} + 11'd1;
            check("thermometer", 32'(ext[W-1:0] & clkp), 32'h0);
            check("single_change", 32'($countones(clkp ^ prev) <= 1), 32'd1);
            if (instFlag) inst_cnt++;
            prev = clkp;
        end
        check("inst_pulse_count", 32'(inst_cnt), 32'd50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
